parity_frame_rx: RTL



---
 rtl/parity_pkg.sv | 18 +
 rtl/sync_2ff.sv | 30 +++
 rtl/parity_frame_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter, receiver and checker.
package parity_pkg;

  // Payload layout shared with the parity generator and checker.
  localparam int unsigned DATA_BITS = 4;
  localparam int unsigned WORD_W    = 5;

  // Receiver FSM encoding.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for the async rx line; resets to the idle (high) level.
module sync_2ff #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  // Shift the raw input one stage per clock.
  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  // Synchronizer chain; reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/parity_frame_rx.sv
// Async frame receiver: start, 4 data bits LSB first, parity, stop.
// Presents {parity, data} with a valid/ready handshake; flags framing errors and overruns.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]      BitLast = 2'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic [WORD_W-1:0]    word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  sync_2ff #(
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  // Next-state logic for the frame FSM, bit counters and output register.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    word_d       = word_q;
    word_valid_d = word_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    // An accepted word is released; a delivery below may re-arm it in the same cycle.
    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntMid) begin
          // High at mid-bit means the falling edge was a glitch.
          state_d   = rx_s ? StIdle : StData;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 2'd1;
          if (bit_idx_q == BitLast) begin
            state_d = StParity;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (cnt_q == CntLast) begin
          par_d   = rx_s;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntLast) begin
          if (rx_s) begin
            state_d = StIdle;
            if (!word_valid_q || word_ready) begin
              word_d       = {par_q, shreg_q};
              word_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger.
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
